// File: rtl/geofence_pkg.sv
// Shared types and sizes for the geofence frame loader.
// A frame is one object point followed by the six fence vertices.
package geofence_pkg;

    localparam int unsigned W     = 10;
    localparam int unsigned NPTS  = 7;
    localparam int unsigned ID_W  = 8;
    localparam int unsigned IDX_W = $clog2(NPTS);

    typedef struct packed {
        logic [W-1:0] x;
        logic [W-1:0] y;
    } point_t;

    typedef enum logic [1:0] {
        StHold,
        StBurst,
        StWait
    } state_e;

endpackage

// File: rtl/geofence_frame_loader_if.sv
// Point stream, engine bus and result signals of the geofence frame loader.
// The slave modport is the loader; the master modport is its environment.
interface geofence_frame_loader_if;
    import geofence_pkg::*;

    logic            in_valid;
    logic            in_ready;
    logic [W-1:0]    in_x;
    logic [W-1:0]    in_y;
    logic            eng_reset;
    logic [W-1:0]    eng_x;
    logic [W-1:0]    eng_y;
    logic            eng_valid;
    logic            eng_inside;
    logic            res_valid;
    logic            res_inside;
    logic [ID_W-1:0] res_id;
    logic            res_err;
    logic            busy;

    modport slave (
        input  in_valid, in_x, in_y, eng_valid, eng_inside,
        output in_ready, eng_reset, eng_x, eng_y, res_valid, res_inside, res_id, res_err, busy
    );

    modport master (
        output in_valid, in_x, in_y, eng_valid, eng_inside,
        input  in_ready, eng_reset, eng_x, eng_y, res_valid, res_inside, res_id, res_err, busy
    );

endinterface

// File: rtl/geofence_pt_bank.sv
// Two-bank ping-pong point store. Writes fill the write bank in order and flip
// banks on the last point; the reader frees its bank and flips when done.
module geofence_pt_bank
    import geofence_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             wr_en,
    input  point_t           wr_pt,
    output logic             wr_full,
    input  logic [IDX_W-1:0] rd_idx,
    input  logic             rd_free,
    output point_t           rd_pt,
    output logic             rd_full
);
    localparam logic [IDX_W-1:0] LastIdx = IDX_W'(NPTS - 1);

    point_t           mem [2][NPTS];
    logic [1:0]       full_q;
    logic             wr_ptr_q;
    logic             rd_ptr_q;
    logic [IDX_W-1:0] fill_q;

    // A free and a final write on the same edge always target different banks.
    always_ff @(posedge clk) begin
        if (reset) begin
            full_q   <= '0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            fill_q   <= '0;
        end else begin
            if (wr_en) begin
                if (fill_q == LastIdx) begin
                    fill_q           <= '0;
                    full_q[wr_ptr_q] <= 1'b1;
                    wr_ptr_q         <= ~wr_ptr_q;
                end else begin
                    fill_q <= fill_q + IDX_W'(1);
                end
            end
            if (rd_free) begin
                full_q[rd_ptr_q] <= 1'b0;
                rd_ptr_q         <= ~rd_ptr_q;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr_q][fill_q] <= wr_pt;
        end
    end

    assign wr_full = full_q[wr_ptr_q];
    assign rd_full = full_q[rd_ptr_q];
    assign rd_pt   = mem[rd_ptr_q][rd_idx];

endmodule

// File: rtl/geofence_frame_loader.sv
// Buffers 7-point frames and replays each as a single burst to the geofence engine.
// Define GEOFENCE_TIMEOUT_EN to add the engine watchdog (res_err); otherwise res_err is 0.
module geofence_frame_loader
    import geofence_pkg::*;
#(
    parameter int unsigned TIMEOUT = 64
) (
    input logic                    clk,
    input logic                    reset,
    geofence_frame_loader_if.slave ifc
);
    localparam logic [IDX_W-1:0] LastIdx = IDX_W'(NPTS - 1);

    if (NPTS != 7) begin : g_npts_check
        $error("geofence_frame_loader: NPTS is fixed at 7 by the engine");
    end

    state_e           state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             eng_reset_q, eng_reset_d;
    point_t           eng_pt_q, eng_pt_d;
    logic             res_valid_q, res_valid_d;
    logic             res_inside_q, res_inside_d;
    logic [ID_W-1:0]  res_id_q, res_id_d;
    logic [ID_W-1:0]  frame_id_q, frame_id_d;
    logic             wr_en, wr_full, rd_full, rd_free;
    point_t           rd_pt;

`ifdef GEOFENCE_TIMEOUT_EN
    localparam int unsigned TmrW = $clog2(TIMEOUT + 1);
    logic [TmrW-1:0] timer_q, timer_d;
    logic            res_err_q, res_err_d;
`endif

    assign ifc.in_ready = !reset && !wr_full;
    assign wr_en        = ifc.in_valid && ifc.in_ready;

    geofence_pt_bank u_bank (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (wr_en),
        .wr_pt   ('{x: ifc.in_x, y: ifc.in_y}),
        .wr_full (wr_full),
        .rd_idx  (idx_q),
        .rd_free (rd_free),
        .rd_pt   (rd_pt),
        .rd_full (rd_full)
    );

    // idx_q is the next point to drive; it rests at 0 in HOLD so point0 is on the read port.
    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        eng_reset_d  = eng_reset_q;
        eng_pt_d     = eng_pt_q;
        res_valid_d  = 1'b0;
        res_inside_d = res_inside_q;
        res_id_d     = res_id_q;
        frame_id_d   = frame_id_q;
        rd_free      = 1'b0;
`ifdef GEOFENCE_TIMEOUT_EN
        timer_d      = '0;
        res_err_d    = res_err_q;
`endif
        unique case (state_q)
            StHold: begin
                if (rd_full) begin
                    eng_reset_d = 1'b0;
                    eng_pt_d    = rd_pt;
                    idx_d       = IDX_W'(1);
                    state_d     = StBurst;
                end
            end
            StBurst: begin
                eng_pt_d = rd_pt;
                if (idx_q == LastIdx) begin
                    rd_free = 1'b1;
                    idx_d   = '0;
                    state_d = StWait;
                end else begin
                    idx_d = idx_q + IDX_W'(1);
                end
            end
            StWait: begin
                if (ifc.eng_valid) begin
                    res_valid_d  = 1'b1;
                    res_inside_d = ifc.eng_inside;
                    res_id_d     = frame_id_q;
                    frame_id_d   = frame_id_q + ID_W'(1);
                    eng_reset_d  = 1'b1;
                    state_d      = StHold;
`ifdef GEOFENCE_TIMEOUT_EN
                    res_err_d    = 1'b0;
`endif
                end
`ifdef GEOFENCE_TIMEOUT_EN
                else if (timer_q == TmrW'(TIMEOUT - 1)) begin
                    res_valid_d  = 1'b1;
                    res_inside_d = 1'b0;
                    res_err_d    = 1'b1;
                    res_id_d     = frame_id_q;
                    frame_id_d   = frame_id_q + ID_W'(1);
                    eng_reset_d  = 1'b1;
                    state_d      = StHold;
                end else begin
                    timer_d = timer_q + TmrW'(1);
                end
`endif
            end
            default: state_d = StHold;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= StHold;
            idx_q        <= '0;
            eng_reset_q  <= 1'b1;
            eng_pt_q     <= '0;
            res_valid_q  <= 1'b0;
            res_inside_q <= 1'b0;
            res_id_q     <= '0;
            frame_id_q   <= '0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            eng_reset_q  <= eng_reset_d;
            eng_pt_q     <= eng_pt_d;
            res_valid_q  <= res_valid_d;
            res_inside_q <= res_inside_d;
            res_id_q     <= res_id_d;
            frame_id_q   <= frame_id_d;
        end
    end

`ifdef GEOFENCE_TIMEOUT_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            timer_q   <= '0;
            res_err_q <= 1'b0;
        end else begin
            timer_q   <= timer_d;
            res_err_q <= res_err_d;
        end
    end
    assign ifc.res_err = res_err_q;
`else
    assign ifc.res_err = 1'b0;
`endif

    assign ifc.eng_reset  = eng_reset_q;
    assign ifc.eng_x      = eng_pt_q.x;
    assign ifc.eng_y      = eng_pt_q.y;
    assign ifc.res_valid  = res_valid_q;
    assign ifc.res_inside = res_inside_q;
    assign ifc.res_id     = res_id_q;
    assign ifc.busy       = (state_q != StHold);

endmodule

// File: tb/tb_geofence_frame_loader.sv
// Directed bench for geofence_frame_loader with a simple engine model attached.
// The engine answers "inside" only for object (5,4), after eng_lat idle cycles.
module tb_geofence_frame_loader;
    import geofence_pkg::*;

    localparam int unsigned TMO = 20;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   checks = 0;
    int   failures = 0;

    geofence_frame_loader_if ifc ();

    geofence_frame_loader #(
        .TIMEOUT (TMO)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .ifc   (ifc)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Engine model: captures 7 points while out of reset, then holds valid until reset.
    int           ecnt = 0;
    int           ewait = 0;
    int           eng_lat = 2;
    logic         eng_hang = 1'b0;
    logic [W-1:0] obj_x, obj_y;
    always @(posedge clk) begin
        if (ifc.eng_reset) begin
            ecnt           <= 0;
            ewait          <= 0;
            ifc.eng_valid  <= 1'b0;
            ifc.eng_inside <= 1'b0;
        end else if (ecnt < 7) begin
            if (ecnt == 0) begin
                obj_x <= ifc.eng_x;
                obj_y <= ifc.eng_y;
            end
            ecnt <= ecnt + 1;
        end else if (!eng_hang) begin
            if (ewait >= eng_lat) begin
                ifc.eng_valid  <= 1'b1;
                ifc.eng_inside <= (obj_x == W'(5)) && (obj_y == W'(4));
            end else begin
                ewait <= ewait + 1;
            end
        end
    end

    // Burst recorder: 7 bus samples starting at each falling edge of eng_reset.
    logic         prev_er = 1'b1;
    int           bn = 0;
    int           bcnt = 0;
    logic [W-1:0] bx [16][7];
    logic [W-1:0] by [16][7];
    int           bst [16];
    logic         bok [16];
    always @(negedge clk) begin
        if (!ifc.eng_reset && prev_er && bn < 16) begin
            bst[bn]   <= cyc;
            bx[bn][0] <= ifc.eng_x;
            by[bn][0] <= ifc.eng_y;
            bok[bn]   <= 1'b1;
            bcnt      <= 1;
        end else if (bcnt > 0) begin
            bx[bn][bcnt] <= ifc.eng_x;
            by[bn][bcnt] <= ifc.eng_y;
            if (ifc.eng_reset) bok[bn] <= 1'b0;
            bcnt <= (bcnt == 6) ? 0 : bcnt + 1;
            if (bcnt == 6) bn <= bn + 1;
        end
        prev_er <= ifc.eng_reset;
    end

    // Result recorder.
    int              rn = 0;
    logic            rin [16];
    logic [ID_W-1:0] rid [16];
    logic            rerr [16];
    int              rcyc [16];
    always @(negedge clk) begin
        if (ifc.res_valid && rn < 16) begin
            rin[rn]  <= ifc.res_inside;
            rid[rn]  <= ifc.res_id;
            rerr[rn] <= ifc.res_err;
            rcyc[rn] <= cyc;
            rn       <= rn + 1;
        end
    end

    int fx [6] = '{0, 2, 8, 10, 8, 2};
    int fy [6] = '{4, 0, 0, 4, 8, 8};

    function automatic logic [139:0] frame_vec(input int ox, input int oy);
        logic [139:0] v;
        v = {W'(ox), W'(oy), 120'b0};
        for (int i = 0; i < 6; i++) begin
            v[119 - 20 * i -: 20] = {W'(fx[i]), W'(fy[i])};
        end
        return v;
    endfunction

    function automatic logic [139:0] burst_vec(input int b);
        logic [139:0] v;
        for (int i = 0; i < 7; i++) begin
            v[139 - 20 * i -: 20] = {bx[b][i], by[b][i]};
        end
        return v;
    endfunction

    task automatic send_pt(input int x, input int y, output int acc);
        int n;
        n = 0;
        ifc.in_valid = 1'b1;
        ifc.in_x     = W'(x);
        ifc.in_y     = W'(y);
        while (!ifc.in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (n >= 200) begin
            failures++;
            $display("FAIL in_ready_timeout: waited %0d cycles, required < 200", n);
        end
        @(negedge clk);
        acc = cyc;
        ifc.in_valid = 1'b0;
    endtask

    task automatic send_frame(input int ox, input int oy, output int acc);
        send_pt(ox, oy, acc);
        for (int i = 0; i < 6; i++) send_pt(fx[i], fy[i], acc);
    endtask

    task automatic wait_res(input int target, input int limit, output bit ok);
        int n;
        n = 0;
        while (rn < target && n < limit) begin
            @(negedge clk);
            #1;
            n++;
        end
        ok = (rn >= target);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        ifc.in_valid = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        ifc.in_valid = 1'b0;
        ifc.in_x     = '0;
        ifc.in_y     = '0;
        reset        = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if ({ifc.in_ready, ifc.eng_reset, ifc.res_valid, ifc.res_inside, ifc.res_err, ifc.busy}
            !== 6'b010000) begin
            failures++;
            $display("FAIL reset_flags: got %b, required 010000", {ifc.in_ready, ifc.eng_reset,
                     ifc.res_valid, ifc.res_inside, ifc.res_err, ifc.busy});
        end
        checks++;
        if ({ifc.eng_x, ifc.eng_y, ifc.res_id} !== '0) begin
            failures++;
            $display("FAIL reset_bus: eng_x=%0d eng_y=%0d res_id=%0d, required 0", ifc.eng_x,
                     ifc.eng_y, ifc.res_id);
        end
        reset = 1'b0;
        @(negedge clk);
        checks++;
        if ({ifc.in_ready, ifc.eng_reset, ifc.res_valid} !== 3'b110) begin
            failures++;
            $display("FAIL idle_after_reset: got %b, required 110",
                     {ifc.in_ready, ifc.eng_reset, ifc.res_valid});
        end
    endtask

    task automatic test_frame(input string name, input int ox, input int oy,
                              input logic exp_in, input int exp_id);
        int acc, b0, r0;
        bit ok;
        b0 = bn;
        r0 = rn;
        send_frame(ox, oy, acc);
        @(negedge clk);
        checks++;
        if (ifc.busy !== 1'b1) begin
            failures++;
            $display("FAIL %s_busy: got %b, required 1", name, ifc.busy);
        end
        wait_res(r0 + 1, 100, ok);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL %s_res_timeout: results %0d, required %0d", name, rn - r0, 1);
            return;
        end
        checks++;
        if (bst[b0] !== acc + 1) begin
            failures++;
            $display("FAIL %s_latency: burst at %0d, required %0d", name, bst[b0], acc + 1);
        end
        checks++;
        if (bok[b0] !== 1'b1) begin
            failures++;
            $display("FAIL %s_eng_reset_low: got %b, required 1", name, bok[b0]);
        end
        checks++;
        if (burst_vec(b0) !== frame_vec(ox, oy)) begin
            failures++;
            $display("FAIL %s_burst: got %h, required %h", name, burst_vec(b0), frame_vec(ox, oy));
        end
        checks++;
        if ({rin[r0], rid[r0], rerr[r0]} !== {exp_in, ID_W'(exp_id), 1'b0}) begin
            failures++;
            $display("FAIL %s_result: inside=%b id=%0d err=%b, required inside=%b id=%0d err=0",
                     name, rin[r0], rid[r0], rerr[r0], exp_in, exp_id);
        end
        checks++;
        if ({ifc.busy, ifc.eng_reset} !== 2'b01) begin
            failures++;
            $display("FAIL %s_back_to_hold: busy,eng_reset=%b, required 01", name,
                     {ifc.busy, ifc.eng_reset});
        end
    endtask

    task automatic test_stalls();
        int acc, b0, r0;
        bit ok;
        b0 = bn;
        r0 = rn;
        for (int i = 0; i < 7; i++) begin
            ifc.in_valid = 1'b0;
            repeat (2) @(negedge clk);
            if (i == 6) begin
                checks++;
                if ({bn == b0, ifc.eng_reset} !== 2'b11) begin
                    failures++;
                    $display("FAIL stall_early_burst: bursts=%0d eng_reset=%b, required 0 and 1",
                             bn - b0, ifc.eng_reset);
                end
            end
            if (i == 0) send_pt(5, 4, acc);
            else send_pt(fx[i-1], fy[i-1], acc);
        end
        wait_res(r0 + 1, 100, ok);
        checks++;
        if (!ok || bst[b0] !== acc + 1 || burst_vec(b0) !== frame_vec(5, 4)) begin
            failures++;
            $display("FAIL stall_burst: start=%0d got %h, required start=%0d %h", bst[b0],
                     burst_vec(b0), acc + 1, frame_vec(5, 4));
        end
        checks++;
        if ({rin[r0], rid[r0]} !== {1'b1, ID_W'(2)}) begin
            failures++;
            $display("FAIL stall_result: inside=%b id=%0d, required inside=1 id=2", rin[r0],
                     rid[r0]);
        end
    endtask

    task automatic test_back_to_back();
        int acc [21];
        int b0, r0, n, rise;
        int ox [3] = '{5, 100, 5};
        bit ok;
        eng_lat = 0;
        do_reset();
        b0 = bn;
        r0 = rn;
        for (int f = 0; f < 3; f++) begin
            send_pt(ox[f], ox[f] == 5 ? 4 : 100, acc[7 * f]);
            for (int i = 0; i < 6; i++) send_pt(fx[i], fy[i], acc[7 * f + 1 + i]);
        end
        // Bank 0 frees on the same edge as the 14th accept, so 21 accepts are unbroken.
        checks++;
        if (acc[20] - acc[0] !== 20) begin
            failures++;
            $display("FAIL b2b_stream: 21 accepts over %0d edges, required 20", acc[20] - acc[0]);
        end
        checks++;
        if (ifc.in_ready !== 1'b0) begin
            failures++;
            $display("FAIL b2b_backpressure: in_ready=%b, required 0", ifc.in_ready);
        end
        n = 0;
        while (!ifc.in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        rise = cyc;
        #1;
        checks++;
        if (rise !== bst[b0 + 1] + 6) begin
            failures++;
            $display("FAIL b2b_ready_rise: at %0d, required %0d", rise, bst[b0 + 1] + 6);
        end
        wait_res(r0 + 3, 200, ok);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL b2b_res_timeout: results %0d, required 3", rn - r0);
            return;
        end
        checks++;
        if (bst[b0 + 1] !== rcyc[r0] + 1) begin
            failures++;
            $display("FAIL b2b_min_reset: frame1 burst at %0d, required %0d", bst[b0 + 1],
                     rcyc[r0] + 1);
        end
        checks++;
        if ({rid[r0], rid[r0 + 1], rid[r0 + 2]} !== {ID_W'(0), ID_W'(1), ID_W'(2)} ||
            {rin[r0], rin[r0 + 1], rin[r0 + 2]} !== 3'b101) begin
            failures++;
            $display("FAIL b2b_results: ids %0d,%0d,%0d inside %b%b%b, required 0,1,2 101",
                     rid[r0], rid[r0 + 1], rid[r0 + 2], rin[r0], rin[r0 + 1], rin[r0 + 2]);
        end
        checks++;
        if (burst_vec(b0 + 2) !== frame_vec(5, 4)) begin
            failures++;
            $display("FAIL b2b_frame2: got %h, required %h", burst_vec(b0 + 2), frame_vec(5, 4));
        end
        eng_lat = 2;
    endtask

    task automatic test_mid_reset();
        int acc, b0;
        b0 = bn;
        send_frame(5, 4, acc);
        send_pt(100, 100, acc);
        send_pt(fx[0], fy[0], acc);
        send_pt(fx[1], fy[1], acc);
        reset = 1'b1;
        @(negedge clk);
        checks++;
        if ({ifc.eng_reset, ifc.busy, ifc.in_ready, ifc.eng_x, ifc.eng_y} !== {3'b100, 20'b0}) begin
            failures++;
            $display("FAIL midreset_state: eng_reset=%b busy=%b in_ready=%b x=%0d y=%0d, required 1 0 0 0 0",
                     ifc.eng_reset, ifc.busy, ifc.in_ready, ifc.eng_x, ifc.eng_y);
        end
        reset = 1'b0;
        repeat (10) @(negedge clk);
        checks++;
        if ({bn == b0 + 1, ifc.eng_reset, ifc.in_ready} !== 3'b111) begin
            failures++;
            $display("FAIL midreset_banks_empty: bursts=%0d eng_reset=%b in_ready=%b, required 1 1 1",
                     bn - b0, ifc.eng_reset, ifc.in_ready);
        end
        test_frame("after_reset", 100, 100, 1'b0, 0);
    endtask

`ifdef GEOFENCE_TIMEOUT_EN
    task automatic test_timeout();
        int acc, b0, r0;
        bit ok;
        b0 = bn;
        r0 = rn;
        eng_hang = 1'b1;
        send_frame(5, 4, acc);
        wait_res(r0 + 1, TMO + 50, ok);
        checks++;
        if (!ok || rcyc[r0] !== bst[b0] + 6 + TMO) begin
            failures++;
            $display("FAIL timeout_cycle: result at %0d, required %0d", ok ? rcyc[r0] : -1,
                     bst[b0] + 6 + TMO);
        end
        checks++;
        if ({rerr[r0], rin[r0], rid[r0]} !== {2'b10, ID_W'(1)}) begin
            failures++;
            $display("FAIL timeout_result: err=%b inside=%b id=%0d, required err=1 inside=0 id=1",
                     rerr[r0], rin[r0], rid[r0]);
        end
        eng_hang = 1'b0;
        test_frame("post_timeout", 5, 4, 1'b1, 2);
    endtask
`endif

    initial begin
        test_reset();
        test_frame("inside", 5, 4, 1'b1, 0);
        test_frame("outside", 100, 100, 1'b0, 1);
        test_stalls();
        test_back_to_back();
        test_mid_reset();
`ifdef GEOFENCE_TIMEOUT_EN
        test_timeout();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
